// File: rtl/sd_audio_pkg.sv
// Shared constants and helpers for the 1-bit audio path.
//   PCM_W      : PCM sample width (16-bit signed, two's complement)
//   CIC_ORDER  : order of the decimating CIC filter
//   PCM_MAX/MIN: clipping limits of the PCM format
//   cic_width  : integrator/comb width for a given log2 decimation ratio
//   cic_shift  : arithmetic right shift that maps full scale onto PCM
//                (negative means a left shift, for small ratios)
package sd_audio_pkg;
  localparam int PCM_W     = 16;
  localparam int CIC_ORDER = 3;

  localparam logic signed [PCM_W-1:0] PCM_MAX = 16'sh7FFF;
  localparam logic signed [PCM_W-1:0] PCM_MIN = 16'sh8000;

  // Full-scale CIC gain is DECIM^ORDER; two extra bits hold the sign and the
  // +/- full-scale endpoint.
  function automatic int cic_width(input int log2_decim);
    return CIC_ORDER * log2_decim + 2;
  endfunction

  // Full scale 2^(ORDER*log2) must land on 2^(PCM_W-1).
  function automatic int cic_shift(input int log2_decim);
    return CIC_ORDER * log2_decim - (PCM_W - 1);
  endfunction
endpackage

// File: rtl/cic_decimator.sv
// Third-order CIC decimator turning a 1-bit stream into 16-bit signed PCM.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   ce          : clock enable; all filter state frozen while low
//   bit_in      : stream bit (1 -> +1, 0 -> -1)
//   data_out    : PCM sample, updated the clk after each decimation tick
//   data_valid  : one-clk pulse after each tick once the filter has filled
//   sat         : one-clk pulse alongside data_valid when the sample clipped
// Handshake: data_valid is a pure strobe with no ready; data_out holds its
// value until the next tick, so a consumer may sample it any time after the
// strobe.
module cic_decimator
  import sd_audio_pkg::*;
#(
  parameter int LOG2_DECIM = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             bit_in,
  output logic [PCM_W-1:0] data_out,
  output logic             data_valid,
  output logic             sat
);
  localparam int W   = cic_width(LOG2_DECIM);
  localparam int SH  = cic_shift(LOG2_DECIM);
  localparam int SHR = (SH > 0) ? SH : 0;
  localparam int SHL = (SH < 0) ? -SH : 0;
  // Scaling width: room for a left shift plus at least one bit above the
  // PCM sign bit so clipping can be detected.
  localparam int XW0 = W + SHL + 1;
  localparam int XW  = (XW0 > PCM_W + 1) ? XW0 : PCM_W + 1;

  logic [LOG2_DECIM-1:0] cnt;
  logic                  tick;
  logic [1:0]            warm_cnt;
  logic                  warm_done;

  logic signed [W-1:0]   x;
  logic signed [W-1:0]   i1, i2, i3;
  logic signed [W-1:0]   c0_d, c1_d, c2_d;
  logic signed [W-1:0]   c1, c2, c3;
  logic signed [XW-1:0]  c3_x, y_x;
  logic                  sat_hi, sat_lo;
  logic [PCM_W-1:0]      y_sat;

  // DECIM is a power of two, so the counter wraps on its own and the last
  // count is all ones.
  assign tick      = ce && (&cnt);
  assign warm_done = (warm_cnt == 2'd3);

  assign x = bit_in ? W'(1) : {W{1'b1}};

  // Combs evaluated in the tick cycle; result is registered on the next edge.
  assign c1 = i3 - c0_d;
  assign c2 = c1 - c1_d;
  assign c3 = c2 - c2_d;

  assign c3_x = {{(XW-W){c3[W-1]}}, c3};
  assign y_x  = (c3_x >>> SHR) <<< SHL;

  // Clipped when the bits above the PCM sign bit are not a pure sign extension.
  assign sat_hi = ~y_x[XW-1] & (|y_x[XW-2:PCM_W-1]);
  assign sat_lo =  y_x[XW-1] & ~(&y_x[XW-2:PCM_W-1]);
  assign y_sat  = sat_hi ? PCM_MAX : (sat_lo ? PCM_MIN : y_x[PCM_W-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      warm_cnt   <= '0;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      c0_d       <= '0;
      c1_d       <= '0;
      c2_d       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sat        <= 1'b0;
    end else begin
      // Registered every clk so a tick from the previous cycle still strobes
      // even if ce has dropped.
      data_valid <= tick && warm_done;
      sat        <= tick && warm_done && (sat_hi || sat_lo);
      if (ce) begin
        cnt <= cnt + LOG2_DECIM'(1);
        // Registered cascade; wrap-around is intentional and cancels in the combs.
        i1  <= i1 + x;
        i2  <= i2 + i1;
        i3  <= i3 + i2;
      end
      if (tick) begin
        c0_d     <= i3;
        c1_d     <= c1;
        c2_d     <= c2;
        data_out <= y_sat;
        if (!warm_done) warm_cnt <= warm_cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/sigma_delta_adc.sv
// Receive side of the 1-bit audio path: sigma-delta ADC front end.
// The external comparator output is synchronised, returned as the feedback
// bit for the RC network, and decimated to 16-bit signed PCM (same format as
// the DAC's data_in, so the two can be looped back).
// Ports:
//   clk        : system clock, also the bitstream sample clock
//   reset      : asynchronous active-high reset
//   ce         : clock enable; all state frozen while low
//   comp_in    : raw comparator output, asynchronous to clk
//   fb_out     : feedback bit (second synchroniser flop, no further logic)
//   data_out   : signed PCM sample
//   data_valid : one-clk strobe, data_out new
//   sat        : one-clk strobe alongside data_valid when the sample clipped
module sigma_delta_adc
  import sd_audio_pkg::*;
#(
  parameter int DECIM      = 256,
  parameter int LOG2_DECIM = $clog2(DECIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             comp_in,
  output logic             fb_out,
  output logic [PCM_W-1:0] data_out,
  output logic             data_valid,
  output logic             sat
);
  if (DECIM < 16 || DECIM > 1024 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
    $error("sigma_delta_adc: DECIM must be a power of two in 16..1024");
  end
  if ((1 << LOG2_DECIM) != DECIM) begin : g_bad_log2
    $error("sigma_delta_adc: LOG2_DECIM does not match DECIM");
  end

  logic s1, s2;

  // s1 may go metastable on the asynchronous comparator edge; s2 is the
  // clean bit used both for feedback and as the filter input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (ce) begin
      s1 <= comp_in;
      s2 <= s1;
    end
  end

  assign fb_out = s2;

  cic_decimator #(
    .LOG2_DECIM (LOG2_DECIM)
  ) u_cic (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .bit_in     (s2),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sat        (sat)
  );
endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc at DECIM=256.
module tb_sigma_delta_adc;
  localparam int DECIM = 256;
  localparam int LEVEL = 8388608;  // 2^23: analog full scale in the loopback model

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        comp_in;
  logic        fb_out;
  logic [15:0] data_out;
  logic        data_valid;
  logic        sat;

  int checks = 0;
  int errors = 0;

  // Stimulus controls, applied by the driver on the falling edge.
  int mode;       // 0 const0, 1 const1, 2 alt 1/0, 3 1110, 4 1000, 5 loopback
  bit ce_en;
  bit ce_toggle;
  int pidx;

  // Loopback model: first-order DAC modulator, RC smoothing, ADC integrator.
  int   dacc, vin, vint;
  logic dac_bit;

  sigma_delta_adc #(.DECIM(DECIM)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .comp_in    (comp_in),
    .fb_out     (fb_out),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ce = ce_toggle ? ~ce : ce_en;
    case (mode)
      0: comp_in = 1'b0;
      1: comp_in = 1'b1;
      2: comp_in = pidx[0];
      3: comp_in = (pidx[1:0] != 2'd3);
      4: comp_in = (pidx[1:0] == 2'd0);
      default: begin
        dac_bit = (dacc >= 0);
        dacc    = dacc + 8000 - (dac_bit ? 32768 : -32768);
        vin     = vin + (((dac_bit ? LEVEL : -LEVEL) - vin) >>> 4);
        vint    = vint + vin - (fb_out ? LEVEL : -LEVEL);
        comp_in = (vint >= 0);
      end
    endcase
    pidx = pidx + 1;
  end

  task automatic check(input string tag, input int got, input int exp, input int tol);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int sdata();
    return int'($signed(data_out));
  endfunction

  task automatic wait_valid(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (data_valid) ok = 1'b1;
    end
  endtask

  task automatic skip_samples(input string tag, input int k);
    int n;
    bit ok;
    for (int i = 0; i < k; i++) begin
      wait_valid(4*DECIM + 8, n, ok);
      check({tag, "_skip_seen"}, ok, 1, 0);
    end
  endtask

  task automatic next_sample(input string tag, input int exp_val, input int exp_sat, input int tol);
    int n;
    bit ok;
    wait_valid(4*DECIM + 8, n, ok);
    check({tag, "_seen"}, ok, 1, 0);
    if (ok) begin
      check({tag, "_data"}, sdata(), exp_val, tol);
      check({tag, "_sat"}, sat, exp_sat, 0);
    end
  endtask

  initial begin
    int n;
    bit ok;

    reset = 1'b1; ce_en = 1'b1; ce_toggle = 1'b0; mode = 0; pidx = 0;
    dacc = 0; vin = 0; vint = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", sdata(), 0, 0);
    check("rst_valid", data_valid, 0, 0);
    check("rst_sat", sat, 0, 0);
    check("rst_fb", fb_out, 0, 0);

    // 1: warm-up with constant 0; first strobe on the clk after the 4th tick.
    @(negedge clk);
    reset = 1'b0;
    wait_valid(4*DECIM + 8, n, ok);
    check("first_valid_seen", ok, 1, 0);
    check("first_valid_edge", n, 4*DECIM, 0);
    check("first_data", sdata(), -32768, 0);
    check("first_sat", sat, 0, 0);
    @(posedge clk); #1;
    check("valid_one_clk", data_valid, 0, 0);

    // 2: constant 1 clips high; fb_out follows comp_in two clks later.
    mode = 1;
    @(posedge clk); #1;
    check("fb_lag1", fb_out, 0, 0);
    @(posedge clk); #1;
    check("fb_lag2", fb_out, 1, 0);
    skip_samples("c1", 4);
    next_sample("c1_a", 32767, 1, 0);
    next_sample("c1_b", 32767, 1, 0);
    @(posedge clk); #1;
    check("sat_pulse_end", sat, 0, 0);
    mode = 0;
    skip_samples("c0", 4);
    next_sample("c0_a", -32768, 0, 0);
    next_sample("c0_b", -32768, 0, 0);

    // 3: alternating input averages to zero; one sample every DECIM clks.
    mode = 2;
    skip_samples("alt", 4);
    next_sample("alt_a", 0, 0, 0);
    wait_valid(4*DECIM + 8, n, ok);
    check("alt_interval", n, DECIM, 0);
    check("alt_b_data", sdata(), 0, 0);

    // 4: quarter-duty patterns.
    mode = 3;
    skip_samples("p1110", 4);
    next_sample("p1110_a", 16384, 0, 0);
    next_sample("p1110_b", 16384, 0, 0);
    mode = 4;
    skip_samples("p1000", 4);
    next_sample("p1000_a", -16384, 0, 0);
    next_sample("p1000_b", -16384, 0, 0);

    // 5: ce at half rate with constant 1.
    mode = 1;
    ce_toggle = 1'b1;
    skip_samples("ceh", 4);
    next_sample("ceh_a", 32767, 1, 0);
    wait_valid(4*DECIM + 8, n, ok);
    check("ceh_interval", n, 2*DECIM, 0);
    check("ceh_b_data", sdata(), 32767, 0);
    check("ceh_b_sat", sat, 1, 0);

    // ce held low: nothing advances even though comp_in changes.
    ce_toggle = 1'b0;
    ce_en = 1'b0;
    mode = 0;
    wait_valid(3*DECIM, n, ok);
    check("ce_low_no_valid", ok, 0, 0);
    check("ce_low_fb_hold", fb_out, 1, 0);
    check("ce_low_data_hold", sdata(), 32767, 0);

    // 6: loopback from a DAC model at 8000.
    ce_en = 1'b1;
    mode = 5;
    skip_samples("loop", 6);
    next_sample("loop_a", 8000, 0, 64);
    next_sample("loop_b", 8000, 0, 64);
    next_sample("loop_c", 8000, 0, 64);

    // Reset mid-frame clears outputs at once and restarts warm-up.
    repeat (100) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data", sdata(), 0, 0);
    check("mid_rst_valid", data_valid, 0, 0);
    check("mid_rst_sat", sat, 0, 0);
    check("mid_rst_fb", fb_out, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_valid(4*DECIM + 8, n, ok);
    check("rewarm_seen", ok, 1, 0);
    check("rewarm_edge", n, 4*DECIM, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
